rv_ifu: RTL and testbench



---
 rtl/rv_ifu_pkg.sv | 20 ++
 rtl/rv_ifu_pc_reg.sv | 37 +++
 rtl/rv_ifu.sv | 107 ++++++++++
 tb/tb_rv_ifu.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ifu_pkg.sv
// Shared definitions for the instruction-fetch unit: message width, reset PC
// and the fetch FSM state encoding.
package rv_ifu_pkg;

  localparam int          IF_ID_WIDTH      = 64;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  localparam logic [1:0] S_IDLE_ENC = 2'd0;
  localparam logic [1:0] S_REQ_ENC  = 2'd1;
  localparam logic [1:0] S_WAIT_ENC = 2'd2;
  localparam logic [1:0] S_HOLD_ENC = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = S_IDLE_ENC,
    S_REQ  = S_REQ_ENC,
    S_WAIT = S_WAIT_ENC,
    S_HOLD = S_HOLD_ENC
  } ifu_state_e;

endpackage

// File: rtl/rv_ifu_pc_reg.sv
// Architectural PC register: redirect target (word aligned) beats pc+4,
// otherwise the PC holds.
module ysyx22041405_pc_reg #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  input  logic             incr_i,
  output logic [WIDTH-1:0] pc_o
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = {redirect_pc_i[WIDTH-1:2], 2'b00};
    end else if (incr_i) begin
      pc_d = pc_q + WIDTH'(4);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else if (redirect_i || incr_i) begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/rv_ifu.sv
// Instruction-fetch stage: one outstanding imem read at a time, result handed
// to decode as {pc, inst}; redirects squash wrong-path work including in-flight reads.
module rv_ifu
  import rv_ifu_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [WIDTH-1:0]       imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [WIDTH-1:0]       imem_resp_data,
  input  logic                   redirect_valid,
  input  logic [WIDTH-1:0]       redirect_pc,
  output logic                   IF_ID_valid,
  input  logic                   IF_ID_ready,
  output logic [IF_ID_WIDTH-1:0] IF_ID_message
);

  ifu_state_e       state_q, state_d;
  logic             drop_q, drop_d;
  logic [WIDTH-1:0] inst_q, inst_d;
  logic [WIDTH-1:0] pc;
  logic             pcIncr;
  logic             reqFire;
  logic             ifidFire;

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc;
  assign IF_ID_valid    = (state_q == S_HOLD);
  assign IF_ID_message  = {pc, inst_q};

  assign reqFire  = imem_req_valid && imem_req_ready;
  assign ifidFire = IF_ID_valid && IF_ID_ready;

  ysyx22041405_pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i         (clk),
    .rst_ni        (rst),
    .redirect_i    (redirect_valid),
    .redirect_pc_i (redirect_pc),
    .incr_i        (pcIncr),
    .pc_o          (pc)
  );

  // A redirect while a read is outstanding cannot cancel it; drop marks the
  // next response as wrong-path so it is drained rather than forwarded.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    pcIncr  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (reqFire) begin
          state_d = S_WAIT;
          drop_d  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d  = imem_resp_data;
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (ifidFire) begin
          pcIncr  = 1'b1;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
    end
  end

endmodule

// File: tb/tb_rv_ifu.sv
// Lockstep testbench for rv_ifu: inputs driven and outputs sampled 1ns after
// each rising edge; delivered messages are checked against a scoreboard queue.
module tb_rv_ifu;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        IF_ID_valid;
  logic        IF_ID_ready;
  logic [63:0] IF_ID_message;

  int checks = 0;
  int errors = 0;
  logic [63:0] sbQ[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
  } vec_t;

  vec_t vecs[5];

  rv_ifu dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .IF_ID_valid     (IF_ID_valid),
    .IF_ID_ready     (IF_ID_ready),
    .IF_ID_message   (IF_ID_message)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One complete fetch at zero-wait memory, with decode stalling for 'stall'
  // cycles once the message is presented.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input int stall);
    logic [63:0] expMsg;
    checkOutput("req_valid", 64'(imem_req_valid), 64'd1);
    checkOutput("req_addr", 64'(imem_req_addr), 64'(addr));
    imem_req_ready = 1'b1;
    cycle();
    imem_req_ready = 1'b0;
    checkOutput("no_req_in_wait", 64'(imem_req_valid), 64'd0);
    checkOutput("no_valid_in_wait", 64'(IF_ID_valid), 64'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    sbQ.push_back({addr, data});
    cycle();
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    for (int i = 0; i < stall; i++) begin
      checkOutput("hold_valid", 64'(IF_ID_valid), 64'd1);
      checkOutput("hold_msg", IF_ID_message, sbQ[0]);
      checkOutput("hold_no_req", 64'(imem_req_valid), 64'd0);
      cycle();
    end
    checkOutput("msg_valid", 64'(IF_ID_valid), 64'd1);
    if (sbQ.size() == 0) begin
      checkOutput("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      expMsg = sbQ.pop_front();
      checkOutput("msg", IF_ID_message, expMsg);
    end
    IF_ID_ready = 1'b1;
    cycle();
    IF_ID_ready = 1'b0;
    checkOutput("valid_drop_after_fire", 64'(IF_ID_valid), 64'd0);
    checkOutput("req_after_fire", 64'(imem_req_valid), 64'd1);
  endtask

  initial begin
    vecs[0] = '{addr: 32'h8000_0000, data: 32'h0000_0013, stall: 0};
    vecs[1] = '{addr: 32'h8000_0004, data: 32'h0000_0013, stall: 0};
    vecs[2] = '{addr: 32'h8000_0008, data: 32'h0000_0013, stall: 0};
    vecs[3] = '{addr: 32'h8000_000C, data: 32'h0010_0093, stall: 5};
    vecs[4] = '{addr: 32'h8000_0010, data: 32'h0020_0113, stall: 1};

    rst             = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    IF_ID_ready     = 1'b0;

    cycle();
    cycle();
    checkOutput("rst_req_valid", 64'(imem_req_valid), 64'd0);
    checkOutput("rst_req_addr", 64'(imem_req_addr), 64'h8000_0000);
    checkOutput("rst_ifid_valid", 64'(IF_ID_valid), 64'd0);
    checkOutput("rst_msg", IF_ID_message, 64'h8000_0000_0000_0000);

    rst = 1'b1;
    #1;
    checkOutput("idle_no_req", 64'(imem_req_valid), 64'd0);
    cycle();

    $display("[TB] sequential fetch table");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].stall);
    end
    checkOutput("seq_next_addr", 64'(imem_req_addr), 64'h8000_0014);

    $display("[TB] redirect while waiting, late response");
    imem_req_ready = 1'b1;
    cycle();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1002;
    cycle();
    redirect_valid = 1'b0;
    checkOutput("wait_redir_no_req", 64'(imem_req_valid), 64'd0);
    cycle();
    checkOutput("wait_redir_no_req2", 64'(imem_req_valid), 64'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    cycle();
    imem_resp_valid = 1'b0;
    checkOutput("dropped_no_valid", 64'(IF_ID_valid), 64'd0);
    applyStimulus(32'h8000_1000, 32'h0000_0513, 0);

    $display("[TB] redirect coinciding with response");
    imem_req_ready = 1'b1;
    cycle();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0BAD;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h8000_2000;
    cycle();
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    checkOutput("coincide_no_valid", 64'(IF_ID_valid), 64'd0);
    checkOutput("coincide_req", 64'(imem_req_valid), 64'd1);
    checkOutput("coincide_addr", 64'(imem_req_addr), 64'h8000_2000);

    $display("[TB] redirect in hold with decode ready");
    imem_req_ready = 1'b1;
    cycle();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0033;
    cycle();
    imem_resp_valid = 1'b0;
    checkOutput("hold_msg_pre", IF_ID_message, 64'h8000_2000_0000_0033);
    IF_ID_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_3000;
    cycle();
    IF_ID_ready    = 1'b0;
    redirect_valid = 1'b0;
    checkOutput("hold_redir_valid", 64'(IF_ID_valid), 64'd0);
    checkOutput("hold_redir_addr", 64'(imem_req_addr), 64'h8000_3000);

    $display("[TB] redirect in request state, with and without accept");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_4005;
    cycle();
    checkOutput("req_redir_valid", 64'(imem_req_valid), 64'd1);
    checkOutput("req_redir_addr", 64'(imem_req_addr), 64'h8000_4004);
    imem_req_ready = 1'b1;
    redirect_pc    = 32'h8000_5000;
    cycle();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    checkOutput("fire_redir_wait", 64'(imem_req_valid), 64'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0BD2;
    cycle();
    imem_resp_valid = 1'b0;
    checkOutput("fire_redir_drop", 64'(IF_ID_valid), 64'd0);
    checkOutput("fire_redir_addr", 64'(imem_req_addr), 64'h8000_5000);

    $display("[TB] pc wrap and reset mid-wait");
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    cycle();
    redirect_valid = 1'b0;
    applyStimulus(32'hFFFF_FFFC, 32'h0000_006F, 0);
    checkOutput("wrap_addr", 64'(imem_req_addr), 64'h0);
    imem_req_ready = 1'b1;
    cycle();
    imem_req_ready = 1'b0;
    checkOutput("wrap_wait", 64'(imem_req_valid), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("async_req_valid", 64'(imem_req_valid), 64'd0);
    checkOutput("async_req_addr", 64'(imem_req_addr), 64'h8000_0000);
    checkOutput("async_ifid_valid", 64'(IF_ID_valid), 64'd0);
    checkOutput("async_msg", IF_ID_message, 64'h8000_0000_0000_0000);
    cycle();
    cycle();
    rst             = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1234_5678;
    cycle();
    imem_resp_valid = 1'b0;
    checkOutput("post_rst_no_valid", 64'(IF_ID_valid), 64'd0);
    applyStimulus(32'h8000_0000, 32'h0000_0013, 0);
    checkOutput("post_rst_next_addr", 64'(imem_req_addr), 64'h8000_0004);

    if (sbQ.size() != 0) begin
      checkOutput("scoreboard_leftover", 64'(sbQ.size()), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
